// File: rtl/tc_pkg.sv
// Shared definitions for the tc_array timer block: FSM states, register map and CTRL layout.
// The optional prescaler is enabled by defining TC_ARRAY_PRESCALE_EN.
package tc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_CNT  = 2'd2,
        ST_INT  = 2'd3
    } tc_state_e;

    // Word offsets inside one channel's 16-byte window
    localparam logic [1:0] OFF_CTRL     = 2'd0;
    localparam logic [1:0] OFF_PRESET   = 2'd1;
    localparam logic [1:0] OFF_COUNT    = 2'd2;
    localparam logic [1:0] OFF_PRESCALE = 2'd3;

    localparam int CTRL_EN      = 0;
    localparam int CTRL_MODE_LO = 1;
    localparam int CTRL_MODE_HI = 2;
    localparam int CTRL_IM      = 3;

    localparam logic [1:0] MODE_ONESHOT = 2'b00;
    localparam logic [1:0] MODE_RELOAD  = 2'b01;

endpackage

// File: rtl/tc_channel.sv
// One timer channel: CTRL/PRESET/COUNT registers, the IDLE/LOAD/CNT/INT FSM and its interrupt flag.
// TC_ARRAY_PRESCALE_EN adds the PRESCALE register and a tick divider for the CNT state.
module tc_channel
    import tc_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        sel,
    input  logic        we,
    input  logic [1:0]  offset,
    input  logic [31:0] din,
    output logic [31:0] rdata,
    output logic        irq,
    output logic [1:0]  state
);

    tc_state_e   st, st_next;
    logic        en, im, irq_flag;
    logic [1:0]  mode;
    logic [31:0] preset, count;
    logic        wr_ctrl, wr_preset, tick;
    logic        load, dec, set_flag, hw_clr_en, pulse_end;

    assign wr_ctrl   = sel && we && (offset == OFF_CTRL);
    assign wr_preset = sel && we && (offset == OFF_PRESET);

`ifdef TC_ARRAY_PRESCALE_EN
    logic [15:0] prescale, pcnt;
    logic        wr_prescale;

    assign wr_prescale = sel && we && (offset == OFF_PRESCALE);
    assign tick        = (pcnt == prescale);

    always_ff @(posedge clk) begin
        if (reset) begin
            prescale <= '0;
            pcnt     <= '0;
        end else begin
            if (wr_prescale)
                prescale <= din[15:0];
            if (load)
                pcnt <= '0;
            else if (st == ST_CNT && en)
                pcnt <= tick ? 16'd0 : pcnt + 16'd1;
        end
    end
`else
    assign tick = 1'b1;
`endif

    // Expiry also waits for a tick so a prescaled channel spends PRESET+1 full periods in CNT.
    always_comb begin
        st_next   = st;
        load      = 1'b0;
        dec       = 1'b0;
        set_flag  = 1'b0;
        hw_clr_en = 1'b0;
        pulse_end = 1'b0;
        case (st)
            ST_IDLE: if (en) st_next = ST_LOAD;
            ST_LOAD: begin
                load    = 1'b1;
                st_next = ST_CNT;
            end
            ST_CNT: begin
                if (!en) begin
                    st_next = ST_IDLE;
                end else if (tick) begin
                    if (count == '0) begin
                        st_next  = ST_INT;
                        set_flag = 1'b1;
                    end else begin
                        dec = 1'b1;
                    end
                end
            end
            ST_INT: begin
                if (mode == MODE_RELOAD) begin
                    st_next   = ST_LOAD;
                    pulse_end = 1'b1;
                end else begin
                    st_next   = ST_IDLE;
                    hw_clr_en = 1'b1;
                end
            end
            default: st_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            st       <= ST_IDLE;
            en       <= 1'b0;
            mode     <= MODE_ONESHOT;
            im       <= 1'b0;
            preset   <= '0;
            count    <= '0;
            irq_flag <= 1'b0;
        end else begin
            st <= st_next;
            if (load)
                count <= preset;
            else if (dec)
                count <= count - 32'd1;
            if (hw_clr_en)
                en <= 1'b0;
            // Software CTRL write is applied last so it overrides the hardware EN clear.
            if (wr_ctrl) begin
                en   <= din[CTRL_EN];
                mode <= din[CTRL_MODE_HI:CTRL_MODE_LO];
                im   <= din[CTRL_IM];
            end
            if (wr_preset)
                preset <= din;
            if (set_flag)
                irq_flag <= 1'b1;
            else if (pulse_end || wr_ctrl || wr_preset)
                irq_flag <= 1'b0;
        end
    end

    always_comb begin
        rdata = '0;
        case (offset)
            OFF_CTRL:     rdata = {28'd0, im, mode, en};
            OFF_PRESET:   rdata = preset;
            OFF_COUNT:    rdata = count;
`ifdef TC_ARRAY_PRESCALE_EN
            OFF_PRESCALE: rdata = {16'd0, prescale};
`else
            OFF_PRESCALE: rdata = '0;
`endif
            default:      rdata = '0;
        endcase
    end

    assign irq   = im & irq_flag;
    assign state = st;

endmodule

// File: rtl/tc_array.sv
// Array of NCH timer channels behind a 16-byte-per-channel register window at BASE.
// Define TC_ARRAY_PRESCALE_EN to enable the per-channel PRESCALE register.
module tc_array
    import tc_pkg::*;
#(
    parameter int          NCH  = 2,
    parameter logic [31:0] BASE = 32'h0000_7f00
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [31:2]        Addr,
    input  logic               WE,
    input  logic [31:0]        Din,
    output logic [31:0]        Dout,
    output logic [NCH-1:0]     IRQ,
    output logic [2*NCH-1:0]   dbg_state
);

    logic [31:0] byte_addr, rel;
    logic        in_range;
    logic [NCH-1:0] sel;
    logic [31:0] rdata [NCH];

    assign byte_addr = {Addr, 2'b00};
    assign rel       = byte_addr - BASE;
    assign in_range  = (byte_addr >= BASE) && (rel < 32'(16 * NCH));

    for (genvar k = 0; k < NCH; k++) begin : g_ch
        assign sel[k] = in_range && (rel[6:4] == 3'(k));

        tc_channel u_ch (
            .clk    (clk),
            .reset  (reset),
            .sel    (sel[k]),
            .we     (WE),
            .offset (rel[3:2]),
            .din    (Din),
            .rdata  (rdata[k]),
            .irq    (IRQ[k]),
            .state  (dbg_state[2*k +: 2])
        );
    end

    // Out-of-window addresses select no channel and therefore read 0.
    always_comb begin
        Dout = '0;
        for (int k = 0; k < NCH; k++)
            if (sel[k]) Dout = rdata[k];
    end

endmodule

// File: tb/tb_tc_array.sv
// Directed self-checking bench for tc_array (NCH=2, BASE=0x7f00).
// Honours TC_ARRAY_PRESCALE_EN when computing the expected PRESCALE readback.
module tb_tc_array;

    logic        clk;
    logic        reset;
    logic [31:2] addr;
    logic        we;
    logic [31:0] din;
    logic [31:0] dout;
    logic [1:0]  irq;
    logic [3:0]  dbg_state;

    int n_total = 0;
    int n_bad   = 0;

    tc_array #(.NCH(2), .BASE(32'h0000_7f00)) dut (
        .clk       (clk),
        .reset     (reset),
        .Addr      (addr),
        .WE        (we),
        .Din       (din),
        .Dout      (dout),
        .IRQ       (irq),
        .dbg_state (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, bench did not finish");
        $fatal(1);
    end

    // driver tasks
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        addr = a[31:2];
        din  = d;
        we   = 1'b1;
        @(negedge clk);
        we   = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        addr = a[31:2];
        #1;
        d = dout;
    endtask

    // scoreboard check
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    initial begin
        logic [31:0] d;
        logic [31:0] exp_cnt [4];
        int highs;
        bit found;

        reset = 1'b1;
        we    = 1'b0;
        addr  = '0;
        din   = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // reset state: every register of both channels reads 0
        for (int i = 0; i < 8; i++) begin
            rd(32'h7f00 + 32'(4 * i), d);
            check($sformatf("reset_reg_%0d", i), d, 32'h0);
        end
        check("reset_irq", {30'd0, irq}, 32'h0);
        check("reset_state", {28'd0, dbg_state}, 32'h0);

        // ch0 one-shot, PRESET=3, IM=1
        wr(32'h7f04, 32'd3);
        wr(32'h7f00, 32'h9);
        tick();
        tick();
        exp_cnt[0] = 3; exp_cnt[1] = 2; exp_cnt[2] = 1; exp_cnt[3] = 0;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) tick();
            rd(32'h7f08, d);
            check($sformatf("ch0_count_%0d", i), d, exp_cnt[i]);
        end
        check("ch0_irq_before_expiry", {31'd0, irq[0]}, 32'd0);
        tick();
        check("ch0_irq_rise", {31'd0, irq[0]}, 32'd1);
        tick();
        rd(32'h7f00, d);
        check("ch0_en_cleared", d, 32'h8);
        repeat (4) tick();
        check("ch0_irq_held", {31'd0, irq[0]}, 32'd1);

        // upper CTRL bits ignored; the write also clears the held flag
        wr(32'h7f00, 32'hffff_fff0);
        rd(32'h7f00, d);
        check("ch0_ctrl_upper_ignored", d, 32'h0);
        check("ch0_irq_cleared", {31'd0, irq[0]}, 32'd0);

        // PRESET=0: irq three edges after the EN write edge
        wr(32'h7f04, 32'd0);
        wr(32'h7f00, 32'h9);
        tick();
        check("p0_irq_edge1", {31'd0, irq[0]}, 32'd0);
        tick();
        check("p0_irq_edge2", {31'd0, irq[0]}, 32'd0);
        tick();
        check("p0_irq_edge3", {31'd0, irq[0]}, 32'd1);
        wr(32'h7f00, 32'h8);
        check("p0_irq_cleared", {31'd0, irq[0]}, 32'd0);

        // ch1 auto-reload, PRESET=2: one-cycle pulse every 5 cycles
        wr(32'h7f14, 32'd2);
        wr(32'h7f10, 32'hb);
        for (int t = 1; t <= 15; t++) begin
            tick();
            check($sformatf("ch1_pulse_t%0d", t), {31'd0, irq[1]}, {31'd0, (t % 5) == 0});
        end
        rd(32'h7f10, d);
        check("ch1_ctrl_en_kept", d, 32'hb);
        wr(32'h7f10, 32'ha);
        tick();
        rd(32'h7f18, d);
        check("ch1_count_held", d, 32'd2);
        check("ch1_state_idle", {30'd0, dbg_state[3:2]}, 32'd0);
        highs = 0;
        for (int t = 0; t < 12; t++) begin
            tick();
            if (irq[1]) highs++;
        end
        check("ch1_no_pulse_after_stop", 32'(highs), 32'd0);

        // decode: out-of-window addresses
        wr(32'h7f24, 32'hffff_ffff);
        rd(32'h7f24, d);
        check("oob_read_7f24", d, 32'h0);
        rd(32'h7f20, d);
        check("oob_read_7f20", d, 32'h0);
        wr(32'h7efc, 32'hffff_ffff);
        rd(32'h7efc, d);
        check("oob_read_7efc", d, 32'h0);
        rd(32'h7f00, d);
        check("oob_ch0_ctrl", d, 32'h8);
        rd(32'h7f04, d);
        check("oob_ch0_preset", d, 32'h0);
        rd(32'h7f10, d);
        check("oob_ch1_ctrl", d, 32'ha);
        rd(32'h7f14, d);
        check("oob_ch1_preset", d, 32'd2);

        // COUNT is read-only
        wr(32'h7f18, 32'h1234);
        rd(32'h7f18, d);
        check("count_ro", d, 32'd2);

        // PRESCALE slot
        wr(32'h7f0c, 32'h0001_0005);
        rd(32'h7f0c, d);
`ifdef TC_ARRAY_PRESCALE_EN
        check("prescale_read", d, 32'h5);
`else
        check("prescale_read", d, 32'h0);
`endif
        wr(32'h7f0c, 32'h0);

        // reset mid-count abandons the count with no irq
        wr(32'h7f04, 32'd10);
        wr(32'h7f00, 32'h9);
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            rd(32'h7f08, d);
            if (d == 32'd5) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        check("midcount_reached_5", {31'd0, found}, 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        rd(32'h7f08, d);
        check("midreset_count", d, 32'h0);
        rd(32'h7f00, d);
        check("midreset_ctrl", d, 32'h0);
        rd(32'h7f14, d);
        check("midreset_ch1_preset", d, 32'h0);
        check("midreset_state", {28'd0, dbg_state}, 32'h0);
        highs = 0;
        for (int t = 0; t < 20; t++) begin
            tick();
            if (irq != 2'b00) highs++;
        end
        check("midreset_no_irq", 32'(highs), 32'd0);

        // final report
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/tc_array.md
TC_ARRAY -- requirements
Module: tc_array

Interface
REQ-001 SHALL have parameter NCH, default 2, number of timer channels (1..8).
REQ-002 SHALL have parameter BASE, default 32'h0000_7f00, byte base address; channel k occupies BASE+16*k .. BASE+16*k+15.
REQ-003 SHALL have port clk  input  1  the only clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port Addr  input  [31:2]  word address from the CPU bridge.
REQ-006 SHALL have port WE  input  1  write strobe, qualified by address decode inside the block.
REQ-007 SHALL have port Din  input  32  write data.
REQ-008 SHALL have port Dout  output  32  combinational read data for Addr.
REQ-009 SHALL have port IRQ  output  [NCH-1:0]  per-channel interrupt request, bit k = channel k.

Function
REQ-010 SHALL decode per-channel word offsets: 0x0 CTRL (R/W), 0x4 PRESET (R/W), 0x8 COUNT (read-only), 0xC PRESCALE (see Configuration).
REQ-011 SHALL define CTRL bits: [0] EN, [2:1] MODE, [3] IM; bits [31:4] SHALL read 0 and ignore writes.
REQ-012 SHALL ignore WE and return Dout=0 for any Addr outside BASE..BASE+16*NCH-1; writes to COUNT SHALL be ignored.
REQ-013 SHALL run one FSM per channel with states IDLE, LOAD, CNT, INT.
REQ-014 IDLE: EN=1 -> LOAD next cycle; otherwise remain.
REQ-015 LOAD: COUNT<=PRESET -> CNT.
REQ-016 CNT: EN=0 -> IDLE (COUNT held); COUNT==0 -> INT; else COUNT decrements by 1 on each tick.
REQ-017 INT, MODE=01 (auto-reload): irq_flag asserted for exactly this one cycle -> LOAD.
REQ-018 INT, MODE=00/10/11 (one-shot): EN cleared, irq_flag set and held -> IDLE.
REQ-019 A held irq_flag SHALL clear on any software write to that channel's CTRL or PRESET.
REQ-020 IRQ[k] SHALL equal IM_k & irq_flag_k, combinationally.
REQ-021 A software CTRL write in the same cycle as the hardware EN clear SHALL win.
REQ-022 A PRESET write SHALL not disturb COUNT; it takes effect at the next LOAD.
REQ-023 PRESET=0 SHALL give LOAD->CNT->INT: irq_flag in the third cycle after the EN write edge.
REQ-024 COUNT SHALL be 32-bit unsigned and SHALL never wrap below 0.

Reset
REQ-025 reset SHALL force every channel to IDLE, CTRL/PRESET/COUNT/PRESCALE/prescale counter/irq_flag to 0, hence IRQ=0; Dout is then 0 for every address.
REQ-026 reset asserted mid-count SHALL abandon the count with no IRQ pulse.

Configuration
REQ-027 Macro TC_ARRAY_PRESCALE_EN defined: offset 0xC is a R/W 16-bit PRESCALE (upper bits read 0); a tick occurs once every PRESCALE+1 cycles in CNT; the prescale counter restarts at each LOAD.
REQ-028 Macro undefined: offset 0xC reads 0, writes ignored, a tick occurs every cycle in CNT.

Structure
REQ-029 Package tc_pkg SHALL hold the FSM state enum, register offsets, CTRL bit positions and mode encodings.
REQ-030 One sub-module tc_channel (one channel's registers plus FSM) SHALL be instantiated NCH times; tc_array holds only decode and the read mux.

Verification
REQ-031 Reset, then read all offsets of both channels -> 0, IRQ=2'b00.
REQ-032 ch0 PRESET=3, CTRL=4'b1001 -> COUNT reads 3,2,1,0; IRQ[0] rises and holds; EN reads 0; a CTRL write clears IRQ[0].
REQ-033 ch1 PRESET=2, CTRL=4'b1011 -> IRQ[1] one-cycle pulse every 5 cycles, repeating until EN written 0.
REQ-034 Write 0x7f24 with NCH=2 -> no register changes; read 0x7f24 -> 0.
REQ-035 With TC_ARRAY_PRESCALE_EN, PRESCALE=1, PRESET=2, mode 0 -> COUNT decrements every 2nd cycle, IRQ after 6 CNT-state cycles; without macro -> 0xC reads 0.
REQ-036 reset pulsed while COUNT=5 -> COUNT=0, state IDLE, no IRQ.
